// File: rtl/alu_pkg.sv
// Shared definitions for seq_alu: op-select bit positions, FSM states and op decode.
package alu_pkg;

  localparam int OP_AND = 11;
  localparam int OP_OR  = 10;
  localparam int OP_NEG = 9;
  localparam int OP_NOT = 8;
  localparam int OP_ADD = 7;
  localparam int OP_SUB = 6;
  localparam int OP_MUL = 5;
  localparam int OP_DIV = 4;
  localparam int OP_SHR = 3;
  localparam int OP_SHL = 2;
  localparam int OP_ROR = 1;
  localparam int OP_ROL = 0;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

  typedef enum logic [3:0] {
    ALU_ZERO, ALU_INC, ALU_AND, ALU_OR, ALU_NEG, ALU_NOT, ALU_ADD,
    ALU_SUB, ALU_MUL, ALU_DIV, ALU_SHR, ALU_SHL, ALU_ROR, ALU_ROL
  } alu_op_e;

  // PC increment overrides the select; otherwise the highest set select bit wins.
  function automatic alu_op_e decode_op(input logic inc, input logic [11:0] sel);
    alu_op_e op;
    op = ALU_ZERO;
    if (inc)              op = ALU_INC;
    else if (sel[OP_AND]) op = ALU_AND;
    else if (sel[OP_OR])  op = ALU_OR;
    else if (sel[OP_NEG]) op = ALU_NEG;
    else if (sel[OP_NOT]) op = ALU_NOT;
    else if (sel[OP_ADD]) op = ALU_ADD;
    else if (sel[OP_SUB]) op = ALU_SUB;
    else if (sel[OP_MUL]) op = ALU_MUL;
    else if (sel[OP_DIV]) op = ALU_DIV;
    else if (sel[OP_SHR]) op = ALU_SHR;
    else if (sel[OP_SHL]) op = ALU_SHL;
    else if (sel[OP_ROR]) op = ALU_ROR;
    else if (sel[OP_ROL]) op = ALU_ROL;
    return op;
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative signed multiply (radix-2 Booth) and divide (non-restoring on magnitudes).
// hi/lo carry the final result combinationally during the cycle where last=1.
module alu_iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             last,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d;
  logic [WIDTH:0]   pu_q, pu_d, mcand_q, mcand_d;
  logic [WIDTH-1:0] pq_q, pq_d;
  logic             pq1_q, pq1_d;
  logic [WIDTH+1:0] r_q, r_d, dsr_q, dsr_d;
  logic [WIDTH-1:0] dq_q, dq_d, a_q, a_d;
  logic             qneg_q, qneg_d, bz_q, bz_d;

  logic [WIDTH:0]   bsum;
  logic [WIDTH+1:0] rsh, rnx, rfix;
  logic [WIDTH-1:0] quo, rem, amag, bmag;
  logic             unused_rfix;

  // Datapath: one Booth or non-restoring step per cycle, plus final sign fix-up.
  always_comb begin
    cnt_d   = cnt_q;
    div_d   = div_q;
    pu_d    = pu_q;
    mcand_d = mcand_q;
    pq_d    = pq_q;
    pq1_d   = pq1_q;
    r_d     = r_q;
    dsr_d   = dsr_q;
    dq_d    = dq_q;
    a_d     = a_q;
    qneg_d  = qneg_q;
    bz_d    = bz_q;

    unique case ({pq_q[0], pq1_q})
      2'b01:   bsum = pu_q + mcand_q;
      2'b10:   bsum = pu_q - mcand_q;
      default: bsum = pu_q;
    endcase

    // Remainder stays within W+1 signed bits, so dropping r_q[W+1] keeps the sign.
    rsh  = {r_q[WIDTH:0], dq_q[WIDTH-1]};
    rnx  = r_q[WIDTH+1] ? rsh + dsr_q : rsh - dsr_q;
    rfix = rnx[WIDTH+1] ? rnx + dsr_q : rnx;
    quo  = {dq_q[WIDTH-2:0], ~rnx[WIDTH+1]};
    rem  = rfix[WIDTH-1:0];
    amag = A[WIDTH-1] ? -A : A;
    bmag = B[WIDTH-1] ? -B : B;

    if (start_mul) begin
      cnt_d   = CW'(WIDTH);
      div_d   = 1'b0;
      pu_d    = '0;
      mcand_d = {A[WIDTH-1], A};
      pq_d    = B;
      pq1_d   = 1'b0;
    end else if (start_div) begin
      cnt_d  = CW'(WIDTH);
      div_d  = 1'b1;
      r_d    = '0;
      dsr_d  = {2'b00, bmag};
      dq_d   = amag;
      a_d    = A;
      qneg_d = A[WIDTH-1] ^ B[WIDTH-1];
      bz_d   = (B == '0);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      if (div_q) begin
        r_d  = rnx;
        dq_d = quo;
      end else begin
        pu_d  = {bsum[WIDTH], bsum[WIDTH:1]};
        pq_d  = {bsum[0], pq_q[WIDTH-1:1]};
        pq1_d = pq_q[0];
      end
    end

    if (div_q) begin
      if (bz_q) begin
        lo = '1;
        hi = a_q;
      end else begin
        lo = qneg_q ? -quo : quo;
        hi = a_q[WIDTH-1] ? -rem : rem;
      end
    end else begin
      hi = bsum[WIDTH:1];
      lo = {bsum[0], pq_q[WIDTH-1:1]};
    end
  end

  assign last        = (cnt_q == CW'(1));
  assign dz          = div_q & bz_q;
  assign unused_rfix = ^rfix[WIDTH+1:WIDTH];

  // Iteration state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      div_q   <= 1'b0;
      pu_q    <= '0;
      mcand_q <= '0;
      pq_q    <= '0;
      pq1_q   <= 1'b0;
      r_q     <= '0;
      dsr_q   <= '0;
      dq_q    <= '0;
      a_q     <= '0;
      qneg_q  <= 1'b0;
      bz_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pu_q    <= pu_d;
      mcand_q <= mcand_d;
      pq_q    <= pq_d;
      pq1_q   <= pq1_d;
      r_q     <= r_d;
      dsr_q   <= dsr_d;
      dq_q    <= dq_d;
      a_q     <= a_d;
      qneg_q  <= qneg_d;
      bz_q    <= bz_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with start/done handshake.
//   state | meaning
//   IDLE  | accepting start; single-cycle ops complete here
//   MUL   | Booth multiply iterating, busy=1
//   DIV   | non-restoring divide iterating, busy=1
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             incPC,
  input  logic [11:0]      ALUin,
  input  logic [WIDTH-1:0] register,
  input  logic [WIDTH-1:0] busMuxOut,
  output logic [WIDTH-1:0] zlow,
  output logic [WIDTH-1:0] zhigh,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] zlow_q, zlow_d, zhigh_q, zhigh_d;
  logic             done_q, done_d, dz_q, dz_d;
  logic             start_mul, start_div, last, mdz;
  logic [WIDTH-1:0] mhi, mlo;
  alu_op_e          op;

  logic [WIDTH-1:0]   sc_lo, sc_hi;
  logic [WIDTH:0]     add_w, sub_w;
  logic [2*WIDTH-1:0] dbl, rot_r, rot_l;
  logic [SHW-1:0]     sh;
  logic               unused_rot;

  assign op = decode_op(incPC, ALUin);

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clock     (clock),
    .reset     (reset),
    .start_mul (start_mul),
    .start_div (start_div),
    .A         (register),
    .B         (busMuxOut),
    .hi        (mhi),
    .lo        (mlo),
    .last      (last),
    .dz        (mdz)
  );

  // Single-cycle results straight from the operand inputs sampled at the start edge.
  always_comb begin
    sh    = busMuxOut[SHW-1:0];
    add_w = {1'b0, register} + {1'b0, busMuxOut};
    sub_w = {1'b0, register} - {1'b0, busMuxOut};
    dbl   = {register, register};
    rot_r = dbl >> sh;
    rot_l = dbl << sh;
    sc_lo = '0;
    sc_hi = '0;
    unique case (op)
      ALU_INC: sc_lo = busMuxOut + 1'b1;
      ALU_AND: sc_lo = register & busMuxOut;
      ALU_OR:  sc_lo = register | busMuxOut;
      ALU_NEG: sc_lo = -busMuxOut;
      ALU_NOT: sc_lo = ~busMuxOut;
      ALU_ADD: begin
        sc_lo = add_w[WIDTH-1:0];
        sc_hi = {{(WIDTH-1){1'b0}}, add_w[WIDTH]};
      end
      ALU_SUB: begin
        sc_lo = sub_w[WIDTH-1:0];
        sc_hi = {{(WIDTH-1){1'b0}}, sub_w[WIDTH]};
      end
      ALU_SHR: sc_lo = register >> sh;
      ALU_SHL: sc_lo = register << sh;
      ALU_ROR: sc_lo = rot_r[WIDTH-1:0];
      ALU_ROL: sc_lo = rot_l[2*WIDTH-1:WIDTH];
      default: sc_lo = '0;
    endcase
  end

  assign unused_rot = ^{rot_r[2*WIDTH-1:WIDTH], rot_l[WIDTH-1:0]};

  // Next-state and output-register logic.
  always_comb begin
    state_d   = state_q;
    zlow_d    = zlow_q;
    zhigh_d   = zhigh_q;
    done_d    = 1'b0;
    dz_d      = dz_q;
    start_mul = 1'b0;
    start_div = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dz_d = 1'b0;
          if (op == ALU_MUL) begin
            start_mul = 1'b1;
            state_d   = MUL;
          end else if (op == ALU_DIV) begin
            start_div = 1'b1;
            state_d   = DIV;
          end else begin
            zlow_d  = sc_lo;
            zhigh_d = sc_hi;
            done_d  = 1'b1;
          end
        end
      end
      MUL, DIV: begin
        if (last) begin
          zlow_d  = mlo;
          zhigh_d = mhi;
          dz_d    = mdz;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset wins over any start on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      zlow_q  <= '0;
      zhigh_q <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      zlow_q  <= zlow_d;
      zhigh_q <= zhigh_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign zlow     = zlow_q;
  assign zhigh    = zhigh_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multi-cycle successor to the datapath's combinational ALU. It has the same one-hot operation select and PC-increment override, and the same Z-register result pair (`zlow`/`zhigh`). It adds a registered start/done handshake, a generic operand width, and iterative signed multiply and divide that run in WIDTH cycles. The control unit pulses `start` and waits for `done` before clocking the Z registers.

## Interface
- `WIDTH`, default 32: operand and result-half width; must be even and ≥ 8.
- `SHW`, default $clog2(WIDTH): number of shift-amount bits taken from `busMuxOut`.
- `clock`: input, 1 bit. Single clock, rising edge.
- `reset`: input, 1 bit. Synchronous, active-high.
- `start`: input, 1 bit. Launches an operation; honoured only when `busy`=0.
- `incPC`: input, 1 bit. With `start`, computes `busMuxOut`+1. Overrides `ALUin`.
- `ALUin`: input, 12 bits. One-hot op select, highest set bit wins: [11]AND [10]OR [9]NEG [8]NOT [7]ADD [6]SUB [5]MUL [4]DIV [3]SHR [2]SHL [1]ROR [0]ROL.
- `register`: input, WIDTH bits. Operand A, latched at start.
- `busMuxOut`: input, WIDTH bits. Operand B, latched at start.
- `zlow`: output, WIDTH bits. Low result, registered.
- `zhigh`: output, WIDTH bits. High result, registered.
- `busy`: output, 1 bit. High while an operation is in flight.
- `done`: output, 1 bit. One-cycle pulse when `zlow`/`zhigh` are updated.
- `div_zero`: output, 1 bit. Sticky until next accepted start; set when DIV had B=0.

## Operation
- States are IDLE, MUL, DIV. Reset forces IDLE and clears `zlow`, `zhigh`, `busy`, `done` and `div_zero` to 0.
- In IDLE, `start`=1 latches A, B and the decoded op.
  - Any op other than MUL/DIV (including `incPC` and `ALUin`=0) writes its result on that edge. `done`=1 next cycle; the state stays IDLE.
  - MUL or DIV goes to the MUL or DIV state, with `busy`=1 and an iteration counter loaded with WIDTH.
- Single-cycle results; A and B are two's complement:
  - INC: `zlow`=B+1, `zhigh`=0.
  - AND/OR: bitwise A op B, `zhigh`=0.
  - NEG: `zlow`=−B mod 2^WIDTH, `zhigh`=0.
  - NOT: `zlow`=~B, `zhigh`=0.
  - ADD: {`zhigh`,`zlow`} = zero-extended unsigned A+B; `zhigh`[0] is the carry out.
  - SUB: `zlow`=A−B; `zhigh`[0] is the borrow (1 when unsigned A<B).
  - SHR (logical), SHL, ROR, ROL: A by B[SHW-1:0], `zhigh`=0.
  - `ALUin`=0: `zlow`=`zhigh`=0.
- MUL: radix-2 Booth, one iteration per cycle, WIDTH iterations. Result {`zhigh`,`zlow`} is the full 2·WIDTH-bit signed product.
- DIV: signed non-restoring on operand magnitudes, WIDTH iterations, then a sign fix-up in the same final cycle.
  - Quotient truncates toward zero; `zlow`=quotient, `zhigh`=remainder with the sign of A.
  - B=0: `zlow`=all ones, `zhigh`=A, `div_zero`=1; still takes WIDTH cycles.
  - A=MIN, B=−1: `zlow`=MIN, `zhigh`=0.
- `start` while `busy`=1 is ignored and does not queue. `register`/`busMuxOut` changes after the start edge have no effect.
- Between operations, `zlow`/`zhigh` hold the last result.

## Timing
- Start sampled at edge 0.
  - Single-cycle op: `zlow`/`zhigh` valid and `done`=1 after edge 0, i.e. 1-cycle latency; `busy` stays 0.
  - MUL/DIV: `busy`=1 after edge 0. Results are written and `done`=1 after edge WIDTH, with `busy` falling in the same cycle. Latency is WIDTH cycles, so a new start is accepted in the `done` cycle.
- Back-to-back single-cycle starts on consecutive edges each produce a `done` pulse.
- Reset asserted mid-MUL/DIV: on that edge go to IDLE, clear all outputs, and produce no `done`.
- Reset and `start` on the same edge: reset wins.

## Structure
- Shared package `alu_pkg`:
  - op-bit index localparams (OP_AND=11 … OP_ROL=0);
  - state enum {IDLE, MUL, DIV};
  - the priority one-hot-to-op encode function.
- Sub-module `alu_iter_muldiv` holds the Booth/non-restoring datapath, counter and sign fix-up. Its ports are WIDTH parameter, start_mul, start_div, A, B, hi, lo, last, dz. The top holds the FSM, the single-cycle ops and the output registers.

## Test plan
- WIDTH=32, ADD A=FFFFFFFF, B=00000001 -> `zlow`=00000000, `zhigh`=00000001, `done` one cycle after start, `busy` never high.
- MUL A=−3, B=7 -> `busy` 32 cycles; then `zhigh`=FFFFFFFF, `zlow`=FFFFFFEB and one `done` pulse. Repeat with A=80000000, B=80000000 -> `zhigh`=40000000, `zlow`=0.
- DIV A=−17, B=5 -> `zlow`=FFFFFFFD, `zhigh`=FFFFFFFE. DIV A=9, B=0 -> `zlow`=FFFFFFFF, `zhigh`=9, `div_zero`=1, which clears on the next start.
- ROL A=80000001, B=24 (shift 4) -> `zlow`=00000018. `ALUin`=0x0C0 (ADD+SUB set) -> ADD result. `incPC`=1 with B=0x100 -> `zlow`=0x101.
- Start MUL, assert `start` with a new op at cycle 5 -> ignored, MUL result unchanged. Assert `reset` at cycle 10 -> outputs 0, no `done`; a new ADD after reset completes normally.
- WIDTH=8 rerun of the MUL/DIV vectors (−3×7 -> `zhigh`=FF, `zlow`=EB) to check parametrisation and 8-cycle latency.
